// File: rtl/ring_memory_block_n_pkg.sv
`default_nettype none
// ring_mem_pkg: shared types and the round-robin pick for ring_memory_block_n.
// Rev 1.0
package ring_mem_pkg;

   localparam int SEG_AW_DEF = 8;
   localparam int MAX_REQ    = 16;

   typedef logic [SEG_AW_DEF:0] ptr_t;

   typedef enum logic {
      REQ_PUSH = 1'b0,
      REQ_POP  = 1'b1
   } req_kind_e;

   typedef struct packed {
      logic      valid;
      req_kind_e kind;
      logic [2:0] ch;
      logic      error;
   } grant_t;

   // Returns {found, index} of the first pending bit at or after start, modulo n.
   function automatic logic [4:0] rr_next(input logic [MAX_REQ-1:0] pend,
                                          input logic [3:0] start,
                                          input int n);
      logic [4:0] res;
      int idx;
      res = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = (int'(start) + k) % n;
            if (pend[idx[3:0]]) res = {1'b1, idx[3:0]};
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_memory_block_n_if.sv
`default_nettype none
// ring_mem_if: client-side request/response bundle of ring_memory_block_n.
// Rev 1.0
interface ring_mem_if #(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 16,
   parameter int SEG_AW   = 8
);
   logic [CHANNELS-1:0]            push_request;
   logic [CHANNELS*DATA_W-1:0]     push_data;
   logic [CHANNELS-1:0]            push_done;
   logic [CHANNELS-1:0]            push_error;
   logic [CHANNELS-1:0]            pop_request;
   logic [CHANNELS*DATA_W-1:0]     pop_data;
   logic [CHANNELS-1:0]            pop_done;
   logic [CHANNELS-1:0]            pop_error;
   logic [CHANNELS-1:0]            open;
   logic [CHANNELS-1:0]            commit;
   logic [CHANNELS-1:0]            rollback;
   logic [CHANNELS*(SEG_AW+1)-1:0] used;
   logic [CHANNELS-1:0]            full;
   logic [CHANNELS-1:0]            empty;

   modport slave (
      input  push_request, push_data, pop_request, open, commit, rollback,
      output push_done, push_error, pop_data, pop_done, pop_error, used, full, empty
   );

   modport master (
      output push_request, push_data, pop_request, open, commit, rollback,
      input  push_done, push_error, pop_data, pop_done, pop_error, used, full, empty
   );
endinterface
`default_nettype wire

// File: rtl/ring_memory_block_n_ptr_ctrl.sv
`default_nettype none
// ring_ptr_ctrl: one channel's ring pointers, write transaction and status.
// Rev 1.0
module ring_ptr_ctrl #(
   parameter int SEG_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              open,
   input  logic              commit,
   input  logic              rollback,
   input  logic              push_grant,
   input  logic              pop_grant,
   output logic [SEG_AW-1:0] wr_addr,
   output logic [SEG_AW-1:0] rd_addr,
   output logic [SEG_AW:0]   used,
   output logic              full,
   output logic              empty
);
   localparam logic [SEG_AW:0] DEPTH = {1'b1, {SEG_AW{1'b0}}};

   logic [SEG_AW:0] rd_ptr;
   logic [SEG_AW:0] wr_ptr;
   logic [SEG_AW:0] commit_ptr;
   logic [SEG_AW:0] wr_next;
   logic            tx_open;
   logic            push_acc;
   logic            pop_acc;

   // Full counts uncommitted words so an open transaction cannot overrun the reader.
   assign full     = (wr_ptr - rd_ptr) == DEPTH;
   assign empty    = commit_ptr == rd_ptr;
   assign used     = commit_ptr - rd_ptr;
   assign push_acc = push_grant & ~full;
   assign pop_acc  = pop_grant & ~empty;
   assign wr_next  = wr_ptr + {{SEG_AW{1'b0}}, push_acc};
   assign wr_addr  = wr_ptr[SEG_AW-1:0];
   assign rd_addr  = rd_ptr[SEG_AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         tx_open    <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr + {{SEG_AW{1'b0}}, pop_acc};
         if (rollback) begin
            wr_ptr  <= commit_ptr;
            tx_open <= 1'b0;
         end else if (commit) begin
            wr_ptr     <= wr_next;
            commit_ptr <= wr_next;
            tx_open    <= 1'b0;
         end else if (open) begin
            // Snapshot excludes a same-cycle push: that word belongs to the new transaction.
            wr_ptr     <= wr_next;
            commit_ptr <= wr_ptr;
            tx_open    <= 1'b1;
         end else begin
            wr_ptr <= wr_next;
            if (!tx_open) commit_ptr <= wr_next;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/ring_memory_block_n.sv
`default_nettype none
// ring_memory_block_n: N ring buffers sharing one single-port RAM, round-robin served.
// Rev 1.0
module ring_memory_block_n
   import ring_mem_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 16,
   parameter int SEG_AW   = 8,
   parameter int MEM_AW   = SEG_AW + $clog2(CHANNELS)
) (
   input  logic              clk,
   input  logic              rst,
   ring_mem_if.slave         bus,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int NREQ = 2 * CHANNELS;

   logic [NREQ-1:0]     pending;
   logic [NREQ-1:0]     req_in;
   logic [NREQ-1:0]     gnt_onehot;
   logic [3:0]          rr_ptr;
   logic [4:0]          rr_sel;
   grant_t              gnt;
   grant_t              g1;
   logic                pop_v2;
   logic [2:0]          pop_ch2;
   logic                pop_err2;
   logic [MEM_AW-1:0]   addr_sel;
   logic [DATA_W-1:0]   wdata_sel;
   logic [DATA_W-1:0]   pdata [CHANNELS];

   logic [CHANNELS-1:0] push_gnt;
   logic [CHANNELS-1:0] pop_gnt;
   logic [CHANNELS-1:0] full_v;
   logic [CHANNELS-1:0] empty_v;
   logic [SEG_AW-1:0]   wr_addr_a [CHANNELS];
   logic [SEG_AW-1:0]   rd_addr_a [CHANNELS];
   logic [SEG_AW:0]     used_a    [CHANNELS];
   logic [CHANNELS*(SEG_AW+1)-1:0] used_flat;

   logic [CHANNELS-1:0]        push_done_r;
   logic [CHANNELS-1:0]        push_error_r;
   logic [CHANNELS-1:0]        pop_done_r;
   logic [CHANNELS-1:0]        pop_error_r;
   logic [CHANNELS*DATA_W-1:0] pop_data_r;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      ring_ptr_ctrl #(.SEG_AW(SEG_AW)) u_ptr (
         .clk        (clk),
         .rst        (rst),
         .open       (bus.open[c]),
         .commit     (bus.commit[c]),
         .rollback   (bus.rollback[c]),
         .push_grant (push_gnt[c]),
         .pop_grant  (pop_gnt[c]),
         .wr_addr    (wr_addr_a[c]),
         .rd_addr    (rd_addr_a[c]),
         .used       (used_a[c]),
         .full       (full_v[c]),
         .empty      (empty_v[c])
      );
   end

   assign req_in = {bus.pop_request, bus.push_request};
   assign rr_sel = rr_next(MAX_REQ'(pending), rr_ptr, NREQ);

   // Requester index: pushes occupy 0..N-1, pops N..2N-1.
   always_comb begin
      gnt       = '0;
      push_gnt  = '0;
      pop_gnt   = '0;
      addr_sel  = '0;
      wdata_sel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rr_sel[4] && rr_sel[3:0] == 4'(c)) begin
            push_gnt[c] = 1'b1;
            gnt.valid   = 1'b1;
            gnt.kind    = REQ_PUSH;
            gnt.ch      = 3'(c);
            gnt.error   = full_v[c];
            addr_sel    = (MEM_AW'(c) << SEG_AW) | MEM_AW'(wr_addr_a[c]);
            wdata_sel   = pdata[c];
         end
         if (rr_sel[4] && rr_sel[3:0] == 4'(c + CHANNELS)) begin
            pop_gnt[c] = 1'b1;
            gnt.valid  = 1'b1;
            gnt.kind   = REQ_POP;
            gnt.ch     = 3'(c);
            gnt.error  = empty_v[c];
            addr_sel   = (MEM_AW'(c) << SEG_AW) | MEM_AW'(rd_addr_a[c]);
         end
      end
      gnt_onehot = {pop_gnt, push_gnt};
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (bus.push_request[c] && !pending[c])
            pdata[c] <= bus.push_data[c*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending      <= '0;
         rr_ptr       <= '0;
         g1           <= '0;
         pop_v2       <= 1'b0;
         pop_ch2      <= '0;
         pop_err2     <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         push_done_r  <= '0;
         push_error_r <= '0;
         pop_done_r   <= '0;
         pop_error_r  <= '0;
         pop_data_r   <= '0;
      end else begin
         pending <= (pending & ~gnt_onehot) | (req_in & ~pending);
         if (rr_sel[4])
            rr_ptr <= (rr_sel[3:0] == 4'(NREQ - 1)) ? 4'd0 : rr_sel[3:0] + 4'd1;

         g1     <= gnt;
         mem_we <= gnt.valid && gnt.kind == REQ_PUSH && !gnt.error;
         if (gnt.valid && !gnt.error) mem_addr <= addr_sel;
         if (gnt.valid && gnt.kind == REQ_PUSH && !gnt.error) mem_wdata <= wdata_sel;

         // Pops wait one more stage for the RAM's registered read data.
         pop_v2   <= g1.valid && g1.kind == REQ_POP;
         pop_ch2  <= g1.ch;
         pop_err2 <= g1.error;

         push_done_r  <= '0;
         push_error_r <= '0;
         pop_done_r   <= '0;
         pop_error_r  <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            if (g1.valid && g1.kind == REQ_PUSH && g1.ch == 3'(c)) begin
               push_done_r[c]  <= 1'b1;
               push_error_r[c] <= g1.error;
            end
            if (pop_v2 && pop_ch2 == 3'(c)) begin
               pop_done_r[c]  <= 1'b1;
               pop_error_r[c] <= pop_err2;
               pop_data_r[c*DATA_W +: DATA_W] <= pop_err2 ? '0 : mem_rdata;
            end
         end
      end
   end

   always_comb begin
      used_flat = '0;
      for (int c = 0; c < CHANNELS; c++)
         used_flat[c*(SEG_AW+1) +: SEG_AW+1] = used_a[c];
   end

   assign bus.used       = used_flat;
   assign bus.full       = full_v;
   assign bus.empty      = empty_v;
   assign bus.push_done  = push_done_r;
   assign bus.push_error = push_error_r;
   assign bus.pop_done   = pop_done_r;
   assign bus.pop_error  = pop_error_r;
   assign bus.pop_data   = pop_data_r;
endmodule
`default_nettype wire
